// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the REDUX-V multi-cycle control unit.
//   - FSM state encoding and state width
//   - bit positions inside the datapath control vector
//   - opcode constants (opcode 15 is unassigned and decodes as illegal)
//   - instruction class and the latched control-word struct
package multicycle_control_unit_pkg;

   localparam int STATE_W = 3;

   // Codes 5..7 are never entered; the FSM sends them back to FETCH.
   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // Control vector bit positions. SPR is the highest index, so the
   // vector is SIG_SPR+1 bits wide.
   localparam int SIG_BR  = 0;  // branch target select
   localparam int SIG_RA  = 1;  // ULA operand B taken from register A
   localparam int SIG_J   = 2;  // jump target select
   localparam int SIG_RE  = 3;  // register file write enable
   localparam int SIG_DM  = 4;  // write-back source is data memory
   localparam int SIG_WE  = 5;  // data memory write enable
   localparam int SIG_SE  = 6;  // sign-extended immediate operand
   localparam int SIG_RD  = 7;  // destination register from rd field
   localparam int SIG_SP  = 8;  // memory address from stack pointer
   localparam int SIG_SPR = 9;  // stack pointer update
   localparam int SIG_W   = SIG_SPR + 1;

   localparam logic [SIG_W-1:0] SIG_ONE = SIG_W'(1);

   // Bits each phase is allowed to drive from the latched control word.
   localparam logic [SIG_W-1:0] EXEC_MASK =
      (SIG_ONE << SIG_BR) | (SIG_ONE << SIG_J)  | (SIG_ONE << SIG_SE) |
      (SIG_ONE << SIG_RA) | (SIG_ONE << SIG_RD) | (SIG_ONE << SIG_SP) |
      (SIG_ONE << SIG_SPR);
   localparam logic [SIG_W-1:0] MEM_MASK =
      (SIG_ONE << SIG_DM) | (SIG_ONE << SIG_SP) | (SIG_ONE << SIG_SPR) |
      (SIG_ONE << SIG_WE);
   localparam logic [SIG_W-1:0] WB_MASK =
      (SIG_ONE << SIG_RE) | (SIG_ONE << SIG_RD) | (SIG_ONE << SIG_DM);

   // Opcodes. ALU opcodes carry the ULA operation in their low bits.
   localparam int OPC_ADD  = 0;
   localparam int OPC_SUB  = 1;
   localparam int OPC_AND  = 2;
   localparam int OPC_OR   = 3;
   localparam int OPC_XOR  = 4;
   localparam int OPC_SLT  = 5;
   localparam int OPC_ADDI = 6;
   localparam int OPC_MOV  = 7;
   localparam int OPC_LD   = 8;
   localparam int OPC_ST   = 9;
   localparam int OPC_PUSH = 10;
   localparam int OPC_POP  = 11;
   localparam int OPC_BRZR = 12;
   localparam int OPC_JI   = 13;
   localparam int OPC_NOP  = 14;

   typedef enum logic [2:0] {
      CLS_NOP    = 3'd0,
      CLS_ALU    = 3'd1,
      CLS_BRANCH = 3'd2,
      CLS_JUMP   = 3'd3,
      CLS_LOAD   = 3'd4,
      CLS_STORE  = 3'd5
   } op_class_t;

   typedef struct packed {
      logic [SIG_W-1:0] sig;
      op_class_t        cls;
   } ctrl_t;

   function automatic logic [SIG_W-1:0] sig_bit(input int idx);
      return SIG_ONE << idx;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_opcode_decode.sv
// Combinational opcode decoder for REDUX-V.
// Ports:
//   op      in   OP     opcode
//   signals out  SIG_W  full control word (every bit the instruction uses)
//   cls     out  class  instruction class, drives the FSM sequencing
//   legal   out  1      0 for opcodes without a table entry
// Undecodable opcodes return an all-zero word and class NOP.
module multicycle_control_unit_opcode_decode
   import multicycle_control_unit_pkg::*;
#(
   parameter int OP = 4
) (
   input  logic [OP-1:0]    op,
   output logic [SIG_W-1:0] signals,
   output op_class_t        cls,
   output logic             legal
);

   always_comb begin
      signals = '0;
      cls     = CLS_NOP;
      legal   = 1'b1;
      case (op)
         OP'(OPC_ADD), OP'(OPC_SUB), OP'(OPC_AND),
         OP'(OPC_OR),  OP'(OPC_XOR), OP'(OPC_SLT): begin
            signals = sig_bit(SIG_RA) | sig_bit(SIG_RD) | sig_bit(SIG_RE);
            cls     = CLS_ALU;
         end
         OP'(OPC_ADDI): begin
            signals = sig_bit(SIG_SE) | sig_bit(SIG_RD) | sig_bit(SIG_RE);
            cls     = CLS_ALU;
         end
         OP'(OPC_MOV): begin
            signals = sig_bit(SIG_RA) | sig_bit(SIG_RD) | sig_bit(SIG_RE);
            cls     = CLS_ALU;
         end
         OP'(OPC_LD): begin
            signals = sig_bit(SIG_SE) | sig_bit(SIG_DM) | sig_bit(SIG_RD) |
                      sig_bit(SIG_RE);
            cls     = CLS_LOAD;
         end
         OP'(OPC_ST): begin
            signals = sig_bit(SIG_SE) | sig_bit(SIG_WE);
            cls     = CLS_STORE;
         end
         OP'(OPC_PUSH): begin
            signals = sig_bit(SIG_SP) | sig_bit(SIG_SPR) | sig_bit(SIG_WE);
            cls     = CLS_STORE;
         end
         OP'(OPC_POP): begin
            signals = sig_bit(SIG_SP) | sig_bit(SIG_SPR) | sig_bit(SIG_DM) |
                      sig_bit(SIG_RD) | sig_bit(SIG_RE);
            cls     = CLS_LOAD;
         end
         OP'(OPC_BRZR): begin
            signals = sig_bit(SIG_BR) | sig_bit(SIG_SE);
            cls     = CLS_BRANCH;
         end
         OP'(OPC_JI): begin
            signals = sig_bit(SIG_J) | sig_bit(SIG_SE);
            cls     = CLS_JUMP;
         end
         OP'(OPC_NOP): begin
            cls = CLS_NOP;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencing control unit for the REDUX-V datapath.
// Runs FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and gates each bit of the
// latched control word to the phase in which the datapath may use it.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   op         opcode from the instruction register (valid from DECODE)
//   zero       register-A-is-zero flag for BRZR
//   mem_ready  memory port handshake
//   signals    per-phase datapath control vector
//   ula_op     ULA operation, latched in DECODE
//   mem_req    memory request (FETCH and MEM)
//   ir_we      instruction register load strobe
//   pc_we      program counter update strobe
//   state      current FSM state (debug)
//   illegal    one-cycle pulse in DECODE for an undecodable opcode
//   retired    wrapping count of completed instructions
// Handshake: a request is issued by holding mem_req=1; it completes in the
// cycle where mem_req=1 and mem_ready=1, and the FSM advances on that edge.
// mem_ready is ignored whenever mem_req=0.
// While rst is high every strobe and the control vector are forced low, so
// an instruction aborted by reset never writes or retires.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int OP     = 4,
   parameter int ULA_OP = 3,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP-1:0]      op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic [SIG_W-1:0]   signals,
   output logic [ULA_OP-1:0]  ula_op,
   output logic               mem_req,
   output logic               ir_we,
   output logic               pc_we,
   output logic [STATE_W-1:0] state,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   state_t              state_q;
   state_t              state_d;
   ctrl_t               ctrl_q;
   logic [ULA_OP-1:0]   ula_q;
   logic [CNT_W-1:0]    retired_q;
   logic                retire;

   logic [SIG_W-1:0]    dec_sig;
   op_class_t           dec_cls;
   logic                dec_legal;

   multicycle_control_unit_opcode_decode #(
      .OP(OP)
   ) u_decode (
      .op      (op),
      .signals (dec_sig),
      .cls     (dec_cls),
      .legal   (dec_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         ctrl_q     <= '0;
         ula_q      <= '0;
         retired_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            // An illegal opcode is carried through as a NOP.
            ctrl_q.sig <= dec_legal ? dec_sig : '0;
            ctrl_q.cls <= dec_legal ? dec_cls : CLS_NOP;
            ula_q      <= op[ULA_OP-1:0];
         end
         if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      signals = '0;
      mem_req = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            illegal = ~dec_legal;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            signals = ctrl_q.sig & EXEC_MASK;
            case (ctrl_q.cls)
               CLS_BRANCH: begin
                  pc_we   = zero;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               CLS_JUMP: begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               CLS_LOAD, CLS_STORE: begin
                  state_d = S_MEM;
               end
               CLS_ALU: begin
                  state_d = S_WB;
               end
               default: begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            // WE stays up for the whole access; the write lands on the
            // mem_ready cycle.
            mem_req = 1'b1;
            signals = ctrl_q.sig & MEM_MASK;
            if (mem_ready) begin
               if (ctrl_q.cls == CLS_STORE) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            signals = ctrl_q.sig & WB_MASK;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (rst) begin
         signals = '0;
         mem_req = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         illegal = 1'b0;
         retire  = 1'b0;
      end
   end

   assign state   = state_q;
   assign ula_op  = ula_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. The driver walks each instruction
// through its phases, pushing the expected output vector for every cycle
// into exp_q; the monitor pops one entry per falling edge and compares.
module tb_multicycle_control_unit;

   localparam int W = 24;  // {state,signals,mem_req,ir_we,pc_we,illegal,retired,ula_op}

   // control vector bit positions
   localparam int B_BR = 0, B_RA = 1, B_J = 2, B_RE = 3, B_DM = 4;
   localparam int B_WE = 5, B_SE = 6, B_RD = 7, B_SP = 8, B_SPR = 9;

   localparam int C_NOP = 0, C_ALU = 1, C_BRANCH = 2, C_JUMP = 3;
   localparam int C_LOAD = 4, C_STORE = 5;

   logic       clk;
   logic       rst;
   logic [3:0] op;
   logic       zero;
   logic       mem_ready;
   logic [9:0] signals;
   logic [2:0] ula_op;
   logic       mem_req;
   logic       ir_we;
   logic       pc_we;
   logic [2:0] state;
   logic       illegal;
   logic [3:0] retired;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_pass;
   logic [3:0]   m_retired;
   logic [2:0]   m_ula;

   multicycle_control_unit #(
      .OP(4), .ULA_OP(3), .CNT_W(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .signals   (signals),
      .ula_op    (ula_op),
      .mem_req   (mem_req),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .state     (state),
      .illegal   (illegal),
      .retired   (retired)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: bench exceeded time limit, %0d/%0d passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [9:0] b(input int idx);
      logic [9:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic void ref_decode(input logic [3:0] opc, output logic [9:0] w,
                                      output int cls, output logic legal);
      legal = 1'b1;
      w     = '0;
      cls   = C_NOP;
      case (opc)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7: begin
            w = b(B_RA) | b(B_RD) | b(B_RE); cls = C_ALU;
         end
         4'd6:  begin w = b(B_SE) | b(B_RD) | b(B_RE); cls = C_ALU; end
         4'd8:  begin w = b(B_SE) | b(B_DM) | b(B_RD) | b(B_RE); cls = C_LOAD; end
         4'd9:  begin w = b(B_SE) | b(B_WE); cls = C_STORE; end
         4'd10: begin w = b(B_SP) | b(B_SPR) | b(B_WE); cls = C_STORE; end
         4'd11: begin w = b(B_SP) | b(B_SPR) | b(B_DM) | b(B_RD) | b(B_RE); cls = C_LOAD; end
         4'd12: begin w = b(B_BR) | b(B_SE); cls = C_BRANCH; end
         4'd13: begin w = b(B_J) | b(B_SE); cls = C_JUMP; end
         4'd14: begin cls = C_NOP; end
         default: legal = 1'b0;
      endcase
   endfunction

   function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [9:0] sig,
                                         input logic mr, input logic ir, input logic pc,
                                         input logic ill, input logic [3:0] ret,
                                         input logic [2:0] ula);
      return {st, sig, mr, ir, pc, ill, ret, ula};
   endfunction

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cycle(input logic [W-1:0] e);
      exp_q.push_back(e);
      step();
   endtask

   // Runs one instruction. fstall/mstall are not-ready cycles before the
   // fetch/memory access completes. abort>0: stay that many cycles in a
   // stalled MEM, then hold rst for two cycles.
   task automatic run_instr(input logic [3:0] opc, input logic z, input int fstall,
                            input int mstall, input int abort);
      logic [9:0] w;
      logic [9:0] m_exec, m_mem, m_wb;
      int         cls;
      logic       legal;
      logic       pc;
      ref_decode(opc, w, cls, legal);
      m_exec = b(B_BR) | b(B_J) | b(B_SE) | b(B_RA) | b(B_RD) | b(B_SP) | b(B_SPR);
      m_mem  = b(B_DM) | b(B_SP) | b(B_SPR) | b(B_WE);
      m_wb   = b(B_RE) | b(B_RD) | b(B_DM);
      // FETCH: opcode input is not yet meaningful
      for (int i = 0; i <= fstall; i++) begin
         op = 4'($urandom); zero = 1'($urandom);
         mem_ready = (i == fstall);
         expect_cycle(pack(3'd0, 10'd0, 1'b1, mem_ready, mem_ready, 1'b0, m_retired, m_ula));
      end
      // DECODE: no request outstanding, mem_ready must be ignored
      op = opc; zero = 1'($urandom); mem_ready = 1'($urandom);
      expect_cycle(pack(3'd1, 10'd0, 1'b0, 1'b0, 1'b0, ~legal, m_retired, m_ula));
      m_ula = opc[2:0];
      // EXEC
      zero = z; mem_ready = 1'($urandom);
      pc = (cls == C_JUMP) || (cls == C_BRANCH && z);
      expect_cycle(pack(3'd2, w & m_exec, 1'b0, 1'b0, pc, 1'b0, m_retired, m_ula));
      if (cls == C_BRANCH || cls == C_JUMP || cls == C_NOP) begin
         m_retired = m_retired + 4'd1;
         return;
      end
      if (cls == C_LOAD || cls == C_STORE) begin
         if (abort > 0) begin
            for (int i = 0; i < abort; i++) begin
               zero = 1'($urandom); mem_ready = 1'b0;
               expect_cycle(pack(3'd3, w & m_mem, 1'b1, 1'b0, 1'b0, 1'b0, m_retired, m_ula));
            end
            // reset lands while the access is pending; ready arriving now must not commit
            rst = 1'b1; mem_ready = 1'b1;
            expect_cycle(pack(3'd3, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_retired, m_ula));
            m_retired = 4'd0; m_ula = 3'd0;
            expect_cycle(pack(3'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_retired, m_ula));
            rst = 1'b0;
            return;
         end
         for (int i = 0; i <= mstall; i++) begin
            zero = 1'($urandom); mem_ready = (i == mstall);
            expect_cycle(pack(3'd3, w & m_mem, 1'b1, 1'b0, 1'b0, 1'b0, m_retired, m_ula));
         end
         if (cls == C_STORE) begin
            m_retired = m_retired + 4'd1;
            return;
         end
      end
      // WB
      zero = 1'($urandom); mem_ready = 1'($urandom);
      expect_cycle(pack(3'd4, w & m_wb, 1'b0, 1'b0, 1'b0, 1'b0, m_retired, m_ula));
      m_retired = m_retired + 4'd1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {state, signals, mem_req, ir_we, pc_we, illegal, retired, ula_op};
         n_checks++;
         if (a === e) n_pass++;
         else $display("FAIL cycle_vec t=%0t got %h expected %h", $time, a, e);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0; n_pass = 0;
      m_retired = 4'd0; m_ula = 3'd0;
      rst = 1'b1; op = 4'd0; zero = 1'b0; mem_ready = 1'b0;
      step();
      // second reset cycle: reset state, strobes held low
      expect_cycle(pack(3'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0));
      rst = 1'b0;

      run_instr(4'd0,  1'b0, 0, 0, 0);   // ADD, ready tied high
      run_instr(4'd8,  1'b0, 0, 3, 0);   // LD, 3 MEM wait cycles
      run_instr(4'd12, 1'b0, 0, 0, 0);   // BRZR not taken
      run_instr(4'd12, 1'b1, 0, 0, 0);   // BRZR taken
      run_instr(4'd9,  1'b0, 2, 0, 0);   // ST, fetch stalled 2
      run_instr(4'd13, 1'b0, 0, 0, 0);   // JI
      run_instr(4'd10, 1'b0, 0, 0, 2);   // PUSH aborted by reset mid MEM
      for (int i = 0; i < 17; i++)       // counter wraps 15 -> 0 -> 1
         run_instr((i % 2 == 0) ? 4'd14 : 4'd6, 1'b0, 0, 0, 0);
      run_instr(4'd15, 1'b1, 0, 0, 0);   // unassigned opcode
      run_instr(4'd11, 1'b0, 1, 1, 0);   // POP with stalls

      for (int n = 0; n < 200; n++) begin
         logic [3:0] opc;
         int fs, ms;
         opc = 4'($urandom_range(0, 15));
         fs  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         ms  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         run_instr(opc, 1'($urandom), fs, ms, 0);
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain got %0d entries left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequencing control unit for the multi-cycle REDUX-V datapath. It succeeds the single-cycle opcode decoder: it decodes the same opcode set, runs a FETCH/DECODE/EXEC/MEM/WB state machine, and gates each datapath control bit to its phase. Instruction memory and data memory share one port, so both fetch and data access wait on a memory ready handshake. Sits between the instruction register and the datapath/memory port, and adds a retired-instruction counter and an illegal-opcode flag.

Parameters:
OP, 4, opcode width; the decode table covers all 1<<OP codes.
ULA_OP, 3, ULA operation field width; taken from the low ULA_OP bits of the opcode.
CNT_W, 16, retired-instruction counter width.

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
op  in  OP  opcode field of the instruction register; valid from DECODE onward
zero  in  1  register-A-is-zero flag, used by BRZR
mem_ready  in  1  memory port accepted/completed the current request this cycle
signals  out  `SPR+1  per-phase datapath control vector, bit positions per utils.vh
ula_op  out  ULA_OP  ULA operation, registered at DECODE
mem_req  out  1  memory access request (FETCH and MEM states)
ir_we  out  1  instruction register load strobe
pc_we  out  1  program counter update strobe
state  out  3  current state, for debug
illegal  out  1  one-cycle pulse when an undecodable opcode is decoded
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset, synchronous and active-high: on the first edge with rst=1, state=FETCH, signals=0, ula_op=0, mem_req=0, ir_we=0, pc_we=0, illegal=0, retired=0. rst asserted in any state, including mid MEM wait, aborts the instruction; it is not retired and no write strobe is issued on that edge.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5 to 7 are unreachable and recover to FETCH on the next edge.
- FETCH: mem_req=1. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_we=1 and pc_we=1 (PC+1), then go to DECODE.
- DECODE: latch the decode of op into an internal control register; ula_op = op[ULA_OP-1:0]. Always lasts one cycle, then EXEC. If op has no table entry, illegal pulses for this cycle and the instruction executes as NOP.
- EXEC: drive SE/RA/RD/SP/SPR from the control register; ULA evaluates.
  - BRZR: BR=1; pc_we=1 only if zero=1. Then retire and go to FETCH.
  - JI: J=1, pc_we=1. Then retire and go to FETCH.
  - LD/ST/PUSH/POP: go to MEM.
  - All others: go to WB.
  - NOP/illegal: retire and go to FETCH.
- MEM: mem_req=1; DM, SP and SPR held. WE is asserted only while in MEM, so the write commits on the mem_ready=1 cycle. Stays in MEM while mem_ready=0.
  - On mem_ready=1, ST and PUSH retire and go to FETCH.
  - On mem_ready=1, LD and POP go to WB.
- WB: RE=1 for exactly one cycle, with RD/DM muxes held. Retire and go to FETCH.
- WE and RE are never both high. RE is never high outside WB; WE is never high outside MEM.
- Latency with mem_ready tied to 1: BRZR/JI/NOP = 3 cycles; ALU ops, ADDI, MOV, ST, PUSH = 4; LD, POP = 5. Each wait cycle adds 1.
- retired: increments by 1 on each retire edge and wraps modulo 2^CNT_W with no flag.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package/include (utils.vh): opcode constants, signal bit indices (BR, RA, J, RE, DM, WE, SE, SP, SPR, RD), and new state encodings and state-width constant.
- One sub-module, opcode_decode: combinational OP to (signals, class {ALU, BRANCH, JUMP, LOAD, STORE, NOP}, legal). The FSM instantiates it; it is reusable by a future pipelined core.

Test Plan:
- rst=1 for 2 cycles mid MEM wait of a PUSH -> next cycle state=FETCH, WE=0, retired=0, mem_req=0.
- ADD with mem_ready=1 -> state sequence 0,1,2,4,0; RE high only in cycle 4; retired 0 to 1; ula_op=ADD low bits.
- LD with mem_ready low for 3 MEM cycles -> MEM held 4 cycles with mem_req=1; WB follows; total 8 cycles; RE pulses once.
- BRZR with zero=0, then with zero=1 -> pc_we high in EXEC only for zero=1; both retire in 3 cycles.
- ST with FETCH stalled 2 cycles -> ir_we single pulse on the mem_ready edge; WE high only in MEM; RE never asserted.
- CNT_W=4, run 17 NOP/ADDI instructions -> retired wraps 15 to 0 to 1; an unassigned opcode pulses illegal for exactly 1 cycle.
